// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the BCD modulo-N counter.
// Holds the digit width, the largest BCD digit and the modulus-to-BCD conversion.
package bcd_pkg;

    localparam int BCD_MAX    = 9;
    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 6;

    // Converts a non-negative integer into packed BCD, digit 0 in bits [3:0].
    function automatic logic [MAX_DIGITS*DIGIT_W-1:0] to_bcd(input int value);
        logic [MAX_DIGITS*DIGIT_W-1:0] r;
        int v;
        r = '0;
        v = value;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            r[i*DIGIT_W +: DIGIT_W] = DIGIT_W'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the counter: steps by one when carry/borrow-in is set.
// Decrement logic exists only when BCD_COUNTER_DOWN_EN is defined.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_d,
    input  logic               i_up,
    input  logic               i_cin,
    output logic [DIGIT_W-1:0] o_d,
    output logic               o_cout
);

    localparam logic [DIGIT_W-1:0] D_MAX = DIGIT_W'(BCD_MAX);

`ifndef BCD_COUNTER_DOWN_EN
    logic w_unused_up;
    assign w_unused_up = i_up;
`endif

    // Next digit value and carry/borrow towards the next digit up.
    always_comb begin
        o_d    = i_d;
        o_cout = 1'b0;
        if (i_cin) begin
`ifdef BCD_COUNTER_DOWN_EN
            if (i_up) begin
                if (i_d == D_MAX) begin
                    o_d    = '0;
                    o_cout = 1'b1;
                end else begin
                    o_d = i_d + 1'b1;
                end
            end else begin
                if (i_d == '0) begin
                    o_d    = D_MAX;
                    o_cout = 1'b1;
                end else begin
                    o_d = i_d - 1'b1;
                end
            end
`else
            if (i_d == D_MAX) begin
                o_d    = '0;
                o_cout = 1'b1;
            end else begin
                o_d = i_d + 1'b1;
            end
`endif
        end
    end

endmodule

// File: rtl/bcd_modn_counter.sv
// Cascadable BCD modulo-N counter with load, recovery and terminal count.
// Define BCD_COUNTER_DOWN_EN to enable counting down via the up port.
module bcd_modn_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS  = 2,
    parameter int MODULUS = 24
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      en,
    input  logic                      up,
    input  logic                      load,
    input  logic [DIGIT_W*DIGITS-1:0] din,
    output logic [DIGIT_W*DIGITS-1:0] q,
    output logic                      tc,
    output logic                      err
);

    localparam int W = DIGIT_W * DIGITS;
    localparam logic [MAX_DIGITS*DIGIT_W-1:0] TERM_FULL = to_bcd(MODULUS - 1);
    localparam logic [W-1:0] TERM = TERM_FULL[W-1:0];

    if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("bcd_modn_counter: DIGITS out of range 1..6");
    end
    if (MODULUS < 2 || MODULUS > 10**DIGITS) begin : g_bad_modulus
        $error("bcd_modn_counter: MODULUS out of range 2..10^DIGITS");
    end

    // Legal means every digit is a BCD digit and the value is below MODULUS.
    function automatic logic is_legal(input logic [W-1:0] v);
        logic ok;
        ok = (v <= TERM);
        for (int i = 0; i < DIGITS; i++) begin
            if (v[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(BCD_MAX)) ok = 1'b0;
        end
        return ok;
    endfunction

    logic [W-1:0]    r_q;
    logic            r_err;
    logic [W-1:0]    w_q_nx;
    logic            w_err_nx;
    logic [W-1:0]    w_step;
    logic [DIGITS:0] w_carry;
    logic            w_up;
    logic            w_wrap;
    logic [W-1:0]    w_wrap_val;

`ifdef BCD_COUNTER_DOWN_EN
    assign w_up   = up;
    assign w_wrap = w_up ? (r_q == TERM) : w_carry[DIGITS];
    assign tc     = en & (w_up ? (r_q == TERM) : (r_q == '0));
`else
    logic w_unused_up;
    assign w_unused_up = up;
    assign w_up        = 1'b1;
    // A full carry-out from a legal value only happens at TERM.
    assign w_wrap      = (r_q == TERM) | w_carry[DIGITS];
    assign tc          = en & (r_q == TERM);
`endif

    assign w_wrap_val = w_up ? '0 : TERM;
    assign w_carry[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .i_d   (r_q[g*DIGIT_W +: DIGIT_W]),
            .i_up  (w_up),
            .i_cin (w_carry[g]),
            .o_d   (w_step[g*DIGIT_W +: DIGIT_W]),
            .o_cout(w_carry[g+1])
        );
    end

    // Next count and error flag: load beats count, count beats hold.
    always_comb begin
        w_q_nx   = r_q;
        w_err_nx = r_err;
        if (load) begin
            if (is_legal(din)) begin
                w_q_nx   = din;
                w_err_nx = 1'b0;
            end else begin
                w_q_nx   = '0;
                w_err_nx = 1'b1;
            end
        end else if (en) begin
            if (!is_legal(r_q)) begin
                w_q_nx   = '0;
                w_err_nx = 1'b1;
            end else begin
                w_q_nx   = w_wrap ? w_wrap_val : w_step;
                w_err_nx = 1'b0;
            end
        end
    end

    // Count and error registers with asynchronous clear.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_q   <= '0;
            r_err <= 1'b0;
        end else begin
            r_q   <= w_q_nx;
            r_err <= w_err_nx;
        end
    end

    assign q   = r_q;
    assign err = r_err;

endmodule
